// File: rtl/f32_div.sv
// Sequential IEEE-754 binary32 divider, start/done handshake compatible with f32_mult.
// Restoring mantissa division produces one quotient bit per cycle; denormals are flushed.
`timescale 1ns/1ps
module f32_div #(
  parameter logic [31:0] NAN_CANON = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic        done,
  output logic [31:0] p,
  output logic        underflow_o,
  output logic        overflow_o,
  output logic        div_by_zero_o
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV, S_NORM, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [24:0]        rem_q, rem_d;
  logic [23:0]        mb_q, mb_d;
  logic [25:0]        quo_q, quo_d;
  logic signed [9:0]  e_q, e_d;
  logic               sign_q, sign_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        p_q, p_d;
  logic               uf_q, uf_d, of_q, of_d, dz_q, dz_d, done_q, done_d;

  // Operand classification
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s_ab;

  // Datapath temporaries
  logic        rem_ge;
  logic [24:0] rem_diff;
  logic [23:0] mant, mant_fin;
  logic [24:0] mant_rnd;
  logic        guard, sticky, rnd_up;
  logic signed [9:0] e_norm, e_fin;

  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    fa     = a_q[22:0];
    fb     = b_q[22:0];
    a_nan  = (ea == 8'hFF) && (fa != '0);
    b_nan  = (eb == 8'hFF) && (fb != '0);
    a_inf  = (ea == 8'hFF) && (fa == '0);
    b_inf  = (eb == 8'hFF) && (fb == '0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    s_ab   = a_q[31] ^ b_q[31];
  end

  always_comb begin
    rem_ge   = (rem_q >= {1'b0, mb_q});
    rem_diff = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    if (quo_q[25]) begin
      mant   = quo_q[25:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (rem_q != '0);
      e_norm = e_q;
    end else begin
      mant   = quo_q[24:1];
      guard  = quo_q[0];
      sticky = (rem_q != '0);
      e_norm = e_q - 10'sd1;
    end
    rnd_up   = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {24'd0, rnd_up};
    if (mant_rnd[24]) begin
      mant_fin = 24'h80_0000;
      e_fin    = e_norm + 10'sd1;
    end else begin
      mant_fin = mant_rnd[23:0];
      e_fin    = e_norm;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    mb_d    = mb_q;
    quo_d   = quo_q;
    e_d     = e_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    uf_d    = uf_q;
    of_d    = of_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          uf_d    = 1'b0;
          of_d    = 1'b0;
          dz_d    = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        sign_d = s_ab;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          p_d     = NAN_CANON;
          state_d = S_DONE;
        end else if (a_inf) begin
          p_d     = {s_ab, 8'hFF, 23'd0};
          state_d = S_DONE;
        end else if (b_inf) begin
          p_d     = {s_ab, 31'd0};
          state_d = S_DONE;
        end else if (b_zero) begin
          p_d     = {s_ab, 8'hFF, 23'd0};
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else if (a_zero) begin
          p_d     = {s_ab, 31'd0};
          state_d = S_DONE;
        end else begin
          e_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
          rem_d   = {2'b01, fa};
          mb_d    = {1'b1, fb};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // rem stays below 2*mb, so the shifted value always fits in 25 bits
        quo_d = {quo_q[24:0], rem_ge};
        rem_d = {rem_diff[23:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (e_fin >= 10'sd255) begin
          p_d  = {sign_q, 8'hFF, 23'd0};
          of_d = 1'b1;
        end else if (e_fin <= 10'sd0) begin
          p_d  = {sign_q, 31'd0};
          uf_d = 1'b1;
        end else begin
          p_d  = {sign_q, e_fin[7:0], mant_fin[22:0]};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      mb_q    <= '0;
      quo_q   <= '0;
      e_q     <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      mb_q    <= mb_d;
      quo_q   <= quo_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign done          = done_q;
  assign p             = p_q;
  assign underflow_o   = uf_q;
  assign overflow_o    = of_q;
  assign div_by_zero_o = dz_q;

endmodule

// File: doc/f32_div.md
Name: f32_div

Overview:
- Sequential IEEE-754 single-precision divider: computes p = a / b.
- Uses the same start/done handshake as the team's f32_mult, so the same test-vector bench and system FSM can drive it.
- Uses an iterative restoring mantissa divider: one quotient bit per cycle.
- Sits beside f32_mult in the FP datapath and is driven by the same initiator logic.

Parameters:
- NAN_CANON, 32'h7FC0_0000, value returned for every NaN result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- a  in  32  dividend, IEEE-754 binary32.
- b  in  32  divisor, IEEE-754 binary32.
- start  in  1  request; sampled only in IDLE.
- done  out  1  one-cycle pulse; p and flags are valid while done=1.
- p  out  32  quotient.
- underflow_o  out  1  result exponent below 1; result flushed to zero.
- overflow_o  out  1  result exponent of 255 or more; result set to infinity.
- div_by_zero_o  out  1  finite nonzero a divided by zero.

Behaviour:
- Reset (asynchronous, any state, including mid-division):
  - FSM goes to IDLE.
  - done, p, underflow_o, overflow_o, div_by_zero_o all go to 0; iteration counter goes to 0.
- FSM states: IDLE, CHECK, DIV, NORM, DONE.
  - IDLE: start=1 at an edge latches a and b, then goes to CHECK. While not in IDLE, start is ignored and the latched operands are not disturbed.
  - CHECK: unpacks the operands.
    - Denormal inputs are treated as signed zero.
    - Sign = sa ^ sb.
    - Special cases load p and flags and go straight to DONE:
      - Either operand NaN, 0/0, or inf/inf: p = NAN_CANON.
      - inf/finite: p = signed infinity.
      - finite/inf: p = signed zero.
      - Finite nonzero a / zero b: p = signed infinity, div_by_zero_o = 1.
      - Zero a / finite nonzero b: p = signed zero.
    - Otherwise: e = ea - eb + 127, computed as signed 10-bit. Mantissas ma and mb get the hidden 1 (24 bits). rem = ma, counter = 0. Go to DIV.
  - DIV: runs 26 iterations, one per cycle.
    - Each iteration: q = {q, rem >= mb}; if rem >= mb then rem = rem - mb; then rem = rem << 1. rem is 25 bits wide.
    - After iteration 25 the FSM goes to NORM.
  - NORM (normalise, round, pack in one cycle):
    - If q[25]=1: mant = q[25:2], guard = q[1], sticky = q[0] | (rem != 0).
    - If q[25]=0: mant = q[24:1], guard = q[0], sticky = (rem != 0), and e = e - 1.
    - Rounding is round-to-nearest-even: increment when guard & (sticky | mant[0]).
    - If the mantissa carries out on rounding: mant = 24'h800000 and e = e + 1.
    - If e >= 255: p = signed infinity, overflow_o = 1.
    - If e <= 0: p = signed zero, underflow_o = 1. No denormal outputs are produced.
    - Otherwise p = {sign, e[7:0], mant[22:0]}.
    - Go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Latency, counted from the edge that samples start:
  - Normal operands: done is high in the cycle after the 28th following edge.
  - Special operands: done is high in the cycle after the 1st following edge.
- Output holding:
  - p and the flags hold their values after done falls, until the next operation reaches DONE.
  - All flags are cleared on entry to CHECK.
- start=1 in the DONE cycle is ignored. start sampled in IDLE on the very next edge begins a new operation.
- done is registered and never combinationally dependent on start.

Test Plan:
- a=40C00000 (6.0), b=40000000 (2.0), start pulse → done after 28 edges, p=40400000, all flags 0.
- a=3F800000, b=40400000 (1/3) → p=3EAAAAAB; checks round-to-nearest-even with sticky bit. a=BF800000, b=40400000 → p=BEAAAAAB.
- Specials, each with done after 1 edge:
  - 3F800000/00000000 → 7F800000, div_by_zero_o=1.
  - 00000000/00000000 → 7FC00000.
  - 7F800000/7F800000 → 7FC00000.
  - 3F800000/FF800000 → 80000000.
  - 7FC00001/3F800000 → 7FC00000.
- Range limits:
  - 7F000000/00800000 → p=7F800000, overflow_o=1.
  - 00800000/40000000 → p=00000000, underflow_o=1.
  - 00400000 (denormal) / 3F800000 → 00000000, no flags.
- Busy and reset behaviour:
  - Pulse start again with new operands 5 cycles into a division → ignored; the first result (6/2 = 40400000) is unchanged.
  - Assert rst at cycle 10 of a division → done stays 0, p=0. After release, a new 6/2 completes normally.
- Back-to-back operations:
  - Assert start in the first IDLE cycle after done → the second result is correct with the same 28-edge latency.
  - Replay the shared test_vectors.txt file (a, b, expected p) with zero mismatches.
